ddr3_ui_master: RTL and testbench
=================================

DDR3_UI_MASTER -- requirements
Module: ddr3_ui_master

Interface
REQ-001 SHALL have parameter MEM_ADDR_DEPTH, default 28, meaning width of the UI command address.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the request command count.
REQ-003 SHALL have parameter ADDR_STEP, default 8, meaning o_app_addr increment per issued command.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have these ports:
- ui_clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_app_phy_init_done  in  1  memory calibrated
- i_app_rdy  in  1  UI command accept
- i_app_wdf_rdy  in  1  UI write-data accept
- o_app_en  out  1  command valid
- o_app_cmd  out  3  000 = write, 001 = read
- o_app_addr  out  MEM_ADDR_DEPTH  command address
- o_app_wdf_wren  out  1  write beat valid
- o_app_wdf_end  out  1  second (last) beat of a command
- o_app_wdf_data  out  32  write beat data
- i_app_rd_data_valid  in  1  read beat valid
- i_app_rd_data_end  in  1  last beat of a read command
- i_app_rd_data  in  32  read beat data
- i_req_stb  in  1  request strobe
- i_req_write  in  1  1 = write, 0 = read
- i_req_addr  in  MEM_ADDR_DEPTH  start address
- i_req_count  in  COUNT_WIDTH  number of UI commands (2 beats each)
- o_req_ack  out  1  one-cycle request-accepted pulse
- o_busy  out  1  transfer in progress
- i_wr_data  in  32  user write beat
- i_wr_valid  in  1  user write beat valid
- o_wr_ready  out  1  user write beat accepted when high with i_wr_valid
- o_rd_data  out  32  user read beat
- o_rd_valid  out  1  user read beat valid
- o_done  out  1  one-cycle transfer-complete pulse

Function
REQ-006 SHALL implement states IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT, DONE.
REQ-007 SHALL accept a request in IDLE only when i_req_stb=1 and i_app_phy_init_done=1; it SHALL pulse o_req_ack and latch addr, count and direction; a strobe in any other state SHALL be ignored with no ack.
REQ-008 SHALL on an accepted request with count=0 go to DONE and issue no UI traffic.
REQ-009 SHALL hold o_busy=1 in every state except IDLE.
REQ-010 SHALL treat a command as accepted in a cycle with o_app_en=1 and i_app_rdy=1, and SHALL hold o_app_en, o_app_cmd and o_app_addr stable until then.
REQ-011 SHALL advance o_app_addr by ADDR_STEP after each accepted command, wrapping modulo 2^MEM_ADDR_DEPTH.
REQ-012 SHALL in WR_CMD assert o_app_en with cmd 000, and on acceptance go to WR_DATA.
REQ-013 SHALL in WR_DATA drive o_wr_ready = i_app_wdf_rdy, o_app_wdf_wren = i_wr_valid AND i_app_wdf_rdy, and o_app_wdf_data = i_wr_data, all combinationally.
REQ-014 SHALL assert o_app_wdf_end on the second beat of each command; after that beat it SHALL go to WR_CMD if commands remain, else to DONE.
REQ-015 SHALL in RD_CMD assert o_app_en with cmd 001 continuously, issuing one command per cycle while i_app_rdy=1; after the last acceptance it SHALL go to RD_WAIT.
REQ-016 SHALL register each i_app_rd_data_valid beat to o_rd_data/o_rd_valid with 1-cycle latency, in RD_CMD and RD_WAIT only; beats in other states SHALL be dropped.
REQ-017 SHALL count returned beats and go to DONE on receipt of beat number 2*count, even if i_app_rd_data_end is absent; i_app_rd_data_end is informational only.
REQ-018 SHALL pulse o_done for one cycle in DONE, then return to IDLE.
REQ-019 SHALL hold o_app_en, o_app_wdf_wren, o_wr_ready at 0 outside their stated states.
REQ-020 SHALL use a beat counter of COUNT_WIDTH+1 bits so that 2*count never overflows.

Reset
REQ-021 SHALL on rst_n=0, immediately and regardless of state, return to IDLE, clear all counters, and drive every output to 0, including o_app_cmd and o_app_addr.
REQ-022 SHALL ignore i_req_stb until the first rising ui_clk edge after rst_n deasserts.

Verification
REQ-023 The bench SHALL cover a write with addr=0x100, count=2, data 0xA0..0xA3, app_rdy and wdf_rdy held high -> commands at 0x100 and 0x108, 4 wren beats, wdf_end on beats 2 and 4, one o_done.
REQ-024 The bench SHALL cover a read with addr=0x100, count=2 against the DDR3 UI model preloaded by REQ-023 -> o_rd_data 0xA0,0xA1,0xA2,0xA3 in order, o_done one cycle after the 4th beat.
REQ-025 The bench SHALL cover an i_app_rdy low for 3 cycles during RD_CMD -> o_app_en and o_app_addr held stable, no duplicate or skipped address.
REQ-026 The bench SHALL cover i_app_phy_init_done=0 with i_req_stb pulsed -> no o_req_ack and no o_app_en; a count=0 request -> ack, then o_done, with zero UI traffic.
REQ-027 The bench SHALL cover addr=2^28-8, count=2 -> second command address 0x0000000.
REQ-028 The bench SHALL cover rst_n asserted mid-WR_DATA after 1 beat -> all outputs 0 asynchronously, o_busy=0, and a new request accepted normally after release.

Source files
------------

// File: rtl/ddr3_ui_master_if.sv
// Bundle of the DDR3 UI command/write/read channels and the user-side
// request/data channels of ddr3_ui_master. Signal names keep the
// i_/o_ direction as seen from the master.
interface ddr3_ui_master_if #(
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int COUNT_WIDTH    = 16
);
    // DDR3 UI side
    logic                      i_app_phy_init_done;
    logic                      i_app_rdy;
    logic                      i_app_wdf_rdy;
    logic                      o_app_en;
    logic [2:0]                o_app_cmd;
    logic [MEM_ADDR_DEPTH-1:0] o_app_addr;
    logic                      o_app_wdf_wren;
    logic                      o_app_wdf_end;
    logic [31:0]               o_app_wdf_data;
    logic                      i_app_rd_data_valid;
    logic                      i_app_rd_data_end;
    logic [31:0]               i_app_rd_data;

    // user request side
    logic                      i_req_stb;
    logic                      i_req_write;
    logic [MEM_ADDR_DEPTH-1:0] i_req_addr;
    logic [COUNT_WIDTH-1:0]    i_req_count;
    logic                      o_req_ack;
    logic                      o_busy;

    // user data side
    logic [31:0]               i_wr_data;
    logic                      i_wr_valid;
    logic                      o_wr_ready;
    logic [31:0]               o_rd_data;
    logic                      o_rd_valid;
    logic                      o_done;

    modport master (
        input  i_app_phy_init_done, i_app_rdy, i_app_wdf_rdy,
        output o_app_en, o_app_cmd, o_app_addr,
        output o_app_wdf_wren, o_app_wdf_end, o_app_wdf_data,
        input  i_app_rd_data_valid, i_app_rd_data_end, i_app_rd_data,
        input  i_req_stb, i_req_write, i_req_addr, i_req_count,
        output o_req_ack, o_busy,
        input  i_wr_data, i_wr_valid,
        output o_wr_ready, o_rd_data, o_rd_valid, o_done
    );

    modport slave (
        output i_app_phy_init_done, i_app_rdy, i_app_wdf_rdy,
        input  o_app_en, o_app_cmd, o_app_addr,
        input  o_app_wdf_wren, o_app_wdf_end, o_app_wdf_data,
        output i_app_rd_data_valid, i_app_rd_data_end, i_app_rd_data,
        output i_req_stb, i_req_write, i_req_addr, i_req_count,
        input  o_req_ack, o_busy,
        output i_wr_data, i_wr_valid,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_done
    );
endinterface

// File: rtl/ddr3_ui_master.sv
// DDR3 UI master: turns one user request (start address, command count,
// direction) into a run of 2-beat UI write or read commands, streaming
// write beats from the user and returning read beats to the user.
module ddr3_ui_master #(
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int COUNT_WIDTH    = 16,
    parameter int ADDR_STEP      = 8
) (
    input  logic ui_clk,
    input  logic rst_n,
    ddr3_ui_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_RD_CMD,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [MEM_ADDR_DEPTH-1:0] r_addr;
    logic [COUNT_WIDTH-1:0]    r_cmd_left;    // commands still to be issued
    logic [COUNT_WIDTH:0]      r_beats_left;  // read beats still expected (2*count fits)
    logic                      r_beat_sel;    // 0 = first beat of a write command, 1 = second
    logic                      r_req_ack;
    logic                      r_rd_valid;
    logic [31:0]               r_rd_data;

    logic w_req_accept;
    logic w_app_en;
    logic w_cmd_accept;
    logic w_in_wdata;
    logic w_wren;
    logic w_rd_window;
    logic w_rd_beat;
    logic w_last_beat;

    assign w_req_accept = (r_state == S_IDLE) && bus.i_req_stb && bus.i_app_phy_init_done;
    assign w_app_en     = (r_state == S_WR_CMD) || (r_state == S_RD_CMD);
    assign w_cmd_accept = w_app_en && bus.i_app_rdy;
    assign w_in_wdata   = (r_state == S_WR_DATA);
    assign w_wren       = w_in_wdata && bus.i_wr_valid && bus.i_app_wdf_rdy;
    assign w_rd_window  = (r_state == S_RD_CMD) || (r_state == S_RD_WAIT);
    assign w_rd_beat    = w_rd_window && bus.i_app_rd_data_valid;
    // completion is decided purely by the beat count; the UI end flag is not trusted
    assign w_last_beat  = w_rd_beat && (r_beats_left == (COUNT_WIDTH+1)'(1));

    // State register
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_accept) begin
                    if (bus.i_req_count == '0) w_state_next = S_DONE;
                    else if (bus.i_req_write)  w_state_next = S_WR_CMD;
                    else                       w_state_next = S_RD_CMD;
                end
            end
            S_WR_CMD: begin
                if (w_cmd_accept) w_state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                // r_cmd_left was already decremented when this command was accepted
                if (w_wren && r_beat_sel)
                    w_state_next = (r_cmd_left != '0) ? S_WR_CMD : S_DONE;
            end
            S_RD_CMD: begin
                if (w_last_beat)
                    w_state_next = S_DONE;
                else if (w_cmd_accept && (r_cmd_left == COUNT_WIDTH'(1)))
                    w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_last_beat) w_state_next = S_DONE;
            end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address, command and beat bookkeeping
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_cmd_left   <= '0;
            r_beats_left <= '0;
            r_beat_sel   <= 1'b0;
        end else if (w_req_accept) begin
            r_addr       <= bus.i_req_addr;
            r_cmd_left   <= bus.i_req_count;
            r_beats_left <= {bus.i_req_count, 1'b0};
            r_beat_sel   <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_addr     <= r_addr + MEM_ADDR_DEPTH'(ADDR_STEP);
                r_cmd_left <= r_cmd_left - COUNT_WIDTH'(1);
            end
            if (w_wren)
                r_beat_sel <= ~r_beat_sel;
            if (w_rd_beat && (r_beats_left != '0))
                r_beats_left <= r_beats_left - (COUNT_WIDTH+1)'(1);
        end
    end

    // Request acknowledge pulse, one cycle after acceptance
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) r_req_ack <= 1'b0;
        else        r_req_ack <= w_req_accept;
    end

    // Read beat return path, one cycle of latency
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_beat;
            if (w_rd_beat) r_rd_data <= bus.i_app_rd_data;
        end
    end

    assign bus.o_app_en       = w_app_en;
    assign bus.o_app_cmd      = (r_state == S_RD_CMD) ? 3'b001 : 3'b000;
    assign bus.o_app_addr     = r_addr;
    assign bus.o_app_wdf_wren = w_wren;
    assign bus.o_app_wdf_end  = w_wren && r_beat_sel;
    assign bus.o_app_wdf_data = w_in_wdata ? bus.i_wr_data : 32'h0;
    assign bus.o_wr_ready     = w_in_wdata && bus.i_app_wdf_rdy;
    assign bus.o_req_ack      = r_req_ack;
    assign bus.o_busy         = (r_state != S_IDLE);
    assign bus.o_rd_data      = r_rd_data;
    assign bus.o_rd_valid     = r_rd_valid;
    assign bus.o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_ddr3_ui_master.sv
// Bench for ddr3_ui_master: a small DDR3 UI memory model, a user write
// data feeder, a table of request vectors and hand-written corner sequences.
module tb_ddr3_ui_master;

    localparam int AW = 28;
    localparam int CW = 16;

    logic ui_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;

    always #5 ui_clk = ~ui_clk;
    always @(posedge ui_clk) cyc <= cyc + 1;

    ddr3_ui_master_if #(.MEM_ADDR_DEPTH(AW), .COUNT_WIDTH(CW)) ui();

    ddr3_ui_master #(.MEM_ADDR_DEPTH(AW), .COUNT_WIDTH(CW), .ADDR_STEP(8)) dut (
        .ui_clk (ui_clk),
        .rst_n  (rst_n),
        .bus    (ui.master)
    );

    typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        int          cnt;
        bit          init;
        int          exp_ack;
        int          exp_cmds;
        logic [AW-1:0] exp_a1;
        int          exp_beats;
        int          exp_done;
        logic [31:0] dbase;
    } vec_t;

    cmd_t        cmd_log[$];
    beat_t       wd_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_q[$];
    beat_t       rsp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0] mem [logic [AW:0]];
    int          ack_n, done_n, done_cyc, last_in_cyc, wbeat;
    bit          wr_take;
    int          n_checks = 0;
    int          n_errors = 0;

    // DDR3 UI model and output monitor, evaluated mid-cycle
    initial begin
        beat_t b;
        logic [AW:0] key;
        ui.i_app_rd_data_valid = 1'b0;
        ui.i_app_rd_data_end   = 1'b0;
        ui.i_app_rd_data       = 32'h0;
        wbeat = 0;
        forever begin
            @(negedge ui_clk);
            if (ui.o_req_ack) ack_n++;
            if (ui.o_done) begin done_n++; done_cyc = cyc; end
            if (ui.o_rd_valid) rd_log.push_back(ui.o_rd_data);
            wr_take = ui.o_wr_ready && ui.i_wr_valid;
            if (ui.o_app_wdf_wren) begin
                wd_log.push_back('{ui.o_app_wdf_data, ui.o_app_wdf_end});
                if (wr_addr_q.size() != 0) begin
                    key = {wr_addr_q[0], wbeat[0]};
                    mem[key] = ui.o_app_wdf_data;
                end
                if (wbeat == 1) begin
                    wbeat = 0;
                    if (wr_addr_q.size() != 0) void'(wr_addr_q.pop_front());
                end else begin
                    wbeat = 1;
                end
            end
            // present queued read beats before queuing this cycle's command
            if (rsp_q.size() != 0) begin
                b = rsp_q.pop_front();
                ui.i_app_rd_data_valid = 1'b1;
                ui.i_app_rd_data       = b.data;
                ui.i_app_rd_data_end   = b.last;
                last_in_cyc = cyc;
            end else begin
                ui.i_app_rd_data_valid = 1'b0;
                ui.i_app_rd_data_end   = 1'b0;
            end
            if (ui.o_app_en && ui.i_app_rdy) begin
                cmd_log.push_back('{ui.o_app_cmd, ui.o_app_addr});
                if (ui.o_app_cmd == 3'b000) begin
                    wr_addr_q.push_back(ui.o_app_addr);
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        key = {ui.o_app_addr, k[0]};
                        rsp_q.push_back('{mem.exists(key) ? mem[key] : 32'hDEADBEEF, k[0]});
                    end
                end
            end
        end
    end

    // User write-data feeder: head of wr_q, popped after each accepted beat
    initial begin
        ui.i_wr_valid = 1'b0;
        ui.i_wr_data  = 32'h0;
        forever begin
            @(posedge ui_clk);
            #1;
            if (wr_take && wr_q.size() != 0) void'(wr_q.pop_front());
            ui.i_wr_valid = (wr_q.size() != 0);
            ui.i_wr_data  = (wr_q.size() != 0) ? wr_q[0] : 32'h0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {ui.o_app_en, ui.o_app_cmd, ui.o_app_addr, ui.o_app_wdf_wren,
                ui.o_app_wdf_end, ui.o_app_wdf_data, ui.o_req_ack, ui.o_busy,
                ui.o_wr_ready, ui.o_rd_data, ui.o_rd_valid, ui.o_done};
    endfunction

    function automatic vec_t mk(bit wr, logic [AW-1:0] addr, int cnt, bit init, int ack,
                                int cmds, logic [AW-1:0] a1, int beats, int done,
                                logic [31:0] dbase);
        vec_t v;
        v.wr = wr; v.addr = addr; v.cnt = cnt; v.init = init; v.exp_ack = ack;
        v.exp_cmds = cmds; v.exp_a1 = a1; v.exp_beats = beats; v.exp_done = done;
        v.dbase = dbase;
        return v;
    endfunction

    task automatic clear_logs();
        cmd_log.delete(); wd_log.delete(); rd_log.delete(); wr_q.delete();
        ack_n = 0; done_n = 0; done_cyc = -1; last_in_cyc = -1;
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr, input int cnt);
        ui.i_req_write = wr;
        ui.i_req_addr  = addr;
        ui.i_req_count = CW'(cnt);
        ui.i_req_stb   = 1'b1;
        tick();
        ui.i_req_stb   = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (done_n != 0) break;
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [AW-1:0] ea;
        clear_logs();
        if (v.wr) for (int i = 0; i < 2 * v.cnt; i++) wr_q.push_back(v.dbase + 32'(i));
        ui.i_app_phy_init_done = v.init;
        issue(v.wr, v.addr, v.cnt);
        if (v.exp_done != 0) wait_done(200);
        else repeat (10) tick();
        ui.i_app_phy_init_done = 1'b1;
        $display("vec %0d: wr=%0d addr=%0h cnt=%0d init=%0d -> ack=%0d cmds=%0d wbeats=%0d rbeats=%0d done=%0d",
                 idx, v.wr, v.addr, v.cnt, v.init, ack_n, cmd_log.size(), wd_log.size(),
                 rd_log.size(), done_n);
        check($sformatf("v%0d_ack", idx), ack_n, v.exp_ack);
        check($sformatf("v%0d_done", idx), done_n, v.exp_done);
        check($sformatf("v%0d_cmds", idx), cmd_log.size(), v.exp_cmds);
        for (int i = 0; i < cmd_log.size() && i < v.exp_cmds; i++) begin
            if (i == 0)      ea = v.addr;
            else if (i == 1) ea = v.exp_a1;
            else             ea = v.addr + AW'(8 * i);
            check($sformatf("v%0d_cmd%0d_type", idx, i), cmd_log[i].cmd, v.wr ? 3'b000 : 3'b001);
            check($sformatf("v%0d_cmd%0d_addr", idx, i), cmd_log[i].addr, ea);
        end
        if (v.wr) begin
            check($sformatf("v%0d_wbeats", idx), wd_log.size(), v.exp_beats);
            for (int i = 0; i < wd_log.size() && i < v.exp_beats; i++) begin
                check($sformatf("v%0d_wdata%0d", idx, i), wd_log[i].data, v.dbase + 32'(i));
                check($sformatf("v%0d_wend%0d", idx, i), wd_log[i].last, (i % 2) == 1);
            end
            check($sformatf("v%0d_rbeats", idx), rd_log.size(), 0);
        end else begin
            check($sformatf("v%0d_rbeats", idx), rd_log.size(), v.exp_beats);
            for (int i = 0; i < rd_log.size() && i < v.exp_beats; i++)
                check($sformatf("v%0d_rdata%0d", idx, i), rd_log[i], v.dbase + 32'(i));
            if (v.exp_beats > 0)
                check($sformatf("v%0d_done_lat", idx), done_cyc - last_in_cyc, 1);
            check($sformatf("v%0d_wbeats", idx), wd_log.size(), 0);
        end
        check($sformatf("v%0d_busy_end", idx), ui.o_busy, 1'b0);
    endtask

    vec_t vecs[7];

    initial begin
        ui.i_app_phy_init_done = 1'b1;
        ui.i_app_rdy           = 1'b1;
        ui.i_app_wdf_rdy       = 1'b1;
        ui.i_req_stb           = 1'b0;
        ui.i_req_write         = 1'b0;
        ui.i_req_addr          = '0;
        ui.i_req_count         = '0;

        //           wr addr          cnt init ack cmds a1            beats done dbase
        vecs[0] = mk(1, 28'h0000100,  2,  1,   1,  2,   28'h0000108,  4,    1,   32'hA0);
        vecs[1] = mk(0, 28'h0000100,  2,  1,   1,  2,   28'h0000108,  4,    1,   32'hA0);
        vecs[2] = mk(0, 28'h0000100,  2,  0,   0,  0,   28'h0000000,  0,    0,   32'h00);
        vecs[3] = mk(0, 28'h0000040,  0,  1,   1,  0,   28'h0000000,  0,    1,   32'h00);
        vecs[4] = mk(1, 28'hFFFFFF8,  2,  1,   1,  2,   28'h0000000,  4,    1,   32'hB0);
        vecs[5] = mk(0, 28'hFFFFFF8,  2,  1,   1,  2,   28'h0000000,  4,    1,   32'hB0);
        vecs[6] = mk(1, 28'h0000200,  3,  1,   1,  3,   28'h0000208,  6,    1,   32'hC0);

        // reset state, with a strobe presented while reset is held
        clear_logs();
        repeat (2) tick();
        ui.i_req_stb = 1'b1;
        repeat (2) tick();
        $display("reset: outs=%0h", all_outs());
        check("reset_outputs", all_outs(), '0);
        check("reset_ack", ack_n, 0);
        ui.i_req_stb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // read with i_app_rdy low for 3 cycles after the first command
        clear_logs();
        issue(1'b0, 28'h100, 2);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (cmd_log.size() >= 1) break;
        end
        ui.i_app_rdy = 1'b0;
        ui.i_req_stb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ui_clk);
            check($sformatf("stall%0d_cmd_hold", k),
                  {ui.o_app_en, ui.o_app_cmd, ui.o_app_addr}, {1'b1, 3'b001, 28'h108});
        end
        tick();
        ui.i_req_stb = 1'b0;
        ui.i_app_rdy = 1'b1;
        wait_done(200);
        $display("stall: cmds=%0d rbeats=%0d ack=%0d done=%0d", cmd_log.size(), rd_log.size(),
                 ack_n, done_n);
        check("stall_cmds", cmd_log.size(), 2);
        if (cmd_log.size() >= 2) check("stall_addr1", cmd_log[1].addr, 28'h108);
        check("stall_ack_once", ack_n, 1);
        check("stall_done", done_n, 1);
        check("stall_rbeats", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            check($sformatf("stall_rdata%0d", i), rd_log[i], 32'hA0 + 32'(i));

        // reset while in WR_DATA after the first beat
        clear_logs();
        wr_q.push_back(32'hD0);
        issue(1'b1, 28'h300, 2);
        for (int k = 0; k < 50; k++) begin
            if (wd_log.size() >= 1) break;
            tick();
        end
        check("rst_seq_beat1", wd_log.size(), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        $display("midreset: outs=%0h busy=%0d", all_outs(), ui.o_busy);
        check("midreset_outputs", all_outs(), '0);
        check("midreset_busy", ui.o_busy, 1'b0);
        wr_addr_q.delete();
        rsp_q.delete();
        wbeat = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        run_vec(7, mk(1, 28'h300, 1, 1, 1, 1, 28'h0, 2, 1, 32'hE0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
